lfsr_rr_arbiter: RTL and testbench
==================================

Name: lfsr_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one external 10-bit LFSR (lfsr10) among N_REQ requesters, for example the CyberPlayer computer player and the game-round timers.
- Drives the LFSR enable, advances it STEPS times per request to decorrelate successive draws, then latches the value and hands it to the granted requester under a req/gnt handshake.
- Sits between lfsr10 and its consumers. It is the only block allowed to drive the LFSR enable.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 10, LFSR and data width.
- STEPS, 4, LFSR advances per draw (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  level request, one bit per requester.
- lfsr_q  in  WIDTH  current LFSR state from lfsr10.
- lfsr_en  out  1  enable to lfsr10.
- gnt  out  N_REQ  one-hot grant.
- rnd_data  out  WIDTH  random value for the granted requester.
- rnd_valid  out  1  rnd_data valid; equals OR of gnt.
- busy  out  1  high in any state other than IDLE.
- grant_count  out  16  saturating count of completed grants.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, gnt=0, rnd_data=0, rnd_valid=0, busy=0, lfsr_en=0, grant_count=0, rr_ptr=N_REQ-1 so requester 0 has first priority.
- All outputs are registered except lfsr_en, which is decoded from state.
- States: IDLE, STEP, LATCH, GRANT.
- IDLE:
  - If req != 0, select idx = first set bit searching rr_ptr+1, rr_ptr+2, ... with wrap modulo N_REQ.
  - Store idx, load step_cnt=STEPS-1, go to STEP. Otherwise stay in IDLE.
- STEP:
  - lfsr_en=1 every cycle.
  - Decrement step_cnt; when step_cnt==0 go to LATCH. This gives exactly STEPS enable cycles.
  - STEP always runs to completion, even if req[idx] drops.
- LATCH (1 cycle, lfsr_en=0):
  - Captures rnd_data <= lfsr_q, which reflects all STEPS advances.
  - If req[idx]==1, go to GRANT.
  - Otherwise abandon: go to IDLE, set rr_ptr=idx, assert no grant, leave grant_count unchanged.
- GRANT:
  - gnt[idx]=1, rnd_valid=1; rnd_data is held stable.
  - Stay while req[idx]==1.
  - On req[idx]==0: next cycle gnt=0 and rnd_valid=0, set rr_ptr=idx, grant_count += 1 (saturates at 16'hFFFF), go to IDLE.
- Latency:
  - req sampled in IDLE at edge E0.
  - gnt/rnd_valid high after edge E0+STEPS+2.
  - Back-to-back draws: the next IDLE decision happens the cycle after release.
- Other requesters' req changes are ignored outside IDLE. Requests are never queued; a level req is simply re-evaluated in IDLE.
- Simultaneous requests in IDLE: resolved strictly round-robin. A requester that just released has lowest priority.
- rnd_data keeps its last value after release until the next LATCH.
- Reset mid-operation returns everything to reset values immediately. lfsr10 has its own reset and is not sequenced by this block.

Optional Feature:
- Macro LFSR_FREE_RUN_EN.
- Defined: lfsr_en is also 1 in every IDLE and GRANT cycle. The LFSR free-runs between draws, so delivered values depend on request timing.
- Undefined: lfsr_en is 1 only in STEP. The delivered sequence is deterministic: the value after each further STEPS advances.
- Handshake and latency are identical in both builds.

Test Plan (build without LFSR_FREE_RUN_EN, STEPS=4, N_REQ=4, lfsr10 XNOR taps 9/6, seed 10'h001):
- Reset, then req=4'b0001 held -> lfsr_en high exactly 4 cycles; gnt=4'b0001 six cycles after the first sampling edge; rnd_data=10'h01F; rnd_valid=1.
- Drop req[0] -> gnt=0 next cycle and grant_count=1. Assert req[0] again -> rnd_data=10'h1FC.
- req=4'b1111 held continuously, each requester releasing one cycle after its grant -> grant order 0,1,2,3,0.
- Requester 2 asserts req for 2 cycles then drops it during STEP -> 4 enables occur, no gnt, grant_count unchanged, rr_ptr=2; next req=4'b1111 grants requester 3.
- Assert reset=0 while in GRANT -> gnt, rnd_valid, busy and grant_count all 0 immediately, without waiting for a clock edge.
- Force grant_count to 16'hFFFF, then complete one grant -> grant_count stays 16'hFFFF.

Source files
------------

// File: rtl/lfsr_rr_arbiter.sv
// lfsr_rr_arbiter: round-robin sequencer that shares one external LFSR among N_REQ requesters.
// For each draw it steps the LFSR STEPS times, latches the value, then hands it to the selected
// requester under a level req / gnt handshake. It is the only driver of the LFSR enable.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   req          level requests, one bit per requester
//   lfsr_q       current LFSR state
//   lfsr_en      LFSR advance enable (decoded from state)
//   gnt          one-hot grant (registered)
//   rnd_data     random value for the granted requester (registered, held after release)
//   rnd_valid    rnd_data valid, equals OR of gnt (registered)
//   busy         high whenever the sequencer is not idle (registered)
//   grant_count  saturating count of completed grants (registered)
//
// Build option: define LFSR_FREE_RUN_EN to also enable the LFSR in every idle and grant cycle.
// Handshake timing is the same in both builds.
module lfsr_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 10,
  parameter int unsigned STEPS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [WIDTH-1:0] lfsr_q,
  output logic             lfsr_en,
  output logic [N_REQ-1:0] gnt,
  output logic [WIDTH-1:0] rnd_data,
  output logic             rnd_valid,
  output logic             busy,
  output logic [15:0]      grant_count
);

  localparam int unsigned IdxW    = $clog2(N_REQ);
  localparam logic [3:0]  StepsM1 = 4'(STEPS - 1);

  typedef enum logic [1:0] {StIdle, StStep, StLatch, StGrant} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]       step_cnt_q, step_cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0] rnd_data_q, rnd_data_d;
  logic             rnd_valid_q, rnd_valid_d;
  logic             busy_q, busy_d;
  logic [15:0]      grant_count_q, grant_count_d;

  logic [IdxW-1:0]  cand;
  logic [IdxW-1:0]  pick_idx;
  logic             pick_found;
  logic [N_REQ-1:0] idx_onehot;

  // Search starts just after the last served requester, so it gets lowest priority.
  always_comb begin
    cand       = rr_ptr_q;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (cand == IdxW'(N_REQ - 1)) ? '0 : cand + 1'b1;
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    idx_onehot        = '0;
    idx_onehot[idx_q] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    rr_ptr_d      = rr_ptr_q;
    step_cnt_d    = step_cnt_q;
    gnt_d         = gnt_q;
    rnd_data_d    = rnd_data_q;
    grant_count_d = grant_count_q;
    lfsr_en       = 1'b0;

    unique case (state_q)
      StIdle: begin
`ifdef LFSR_FREE_RUN_EN
        lfsr_en = 1'b1;
`else
        lfsr_en = 1'b0;
`endif
        if (|req) begin
          idx_d      = pick_idx;
          step_cnt_d = StepsM1;
          state_d    = StStep;
        end
      end
      // Runs to completion regardless of req, so every draw consumes exactly STEPS advances.
      StStep: begin
        lfsr_en = 1'b1;
        if (step_cnt_q == 4'd0) begin
          state_d = StLatch;
        end else begin
          step_cnt_d = step_cnt_q - 4'd1;
        end
      end
      StLatch: begin
        rnd_data_d = lfsr_q;
        if (req[idx_q]) begin
          state_d = StGrant;
        end else begin
          // Requester gave up during stepping: no grant, no count.
          state_d  = StIdle;
          rr_ptr_d = idx_q;
        end
      end
      StGrant: begin
`ifdef LFSR_FREE_RUN_EN
        lfsr_en = 1'b1;
`else
        lfsr_en = 1'b0;
`endif
        // The grant register follows req[idx]; it rises one cycle after entering GRANT.
        if (req[idx_q]) begin
          gnt_d = idx_onehot;
        end else begin
          gnt_d    = '0;
          state_d  = StIdle;
          rr_ptr_d = idx_q;
          if (grant_count_q != 16'hFFFF) begin
            grant_count_d = grant_count_q + 16'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    rnd_valid_d = |gnt_d;
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      rr_ptr_q      <= IdxW'(N_REQ - 1);
      step_cnt_q    <= 4'd0;
      gnt_q         <= '0;
      rnd_data_q    <= '0;
      rnd_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      grant_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      rr_ptr_q      <= rr_ptr_d;
      step_cnt_q    <= step_cnt_d;
      gnt_q         <= gnt_d;
      rnd_data_q    <= rnd_data_d;
      rnd_valid_q   <= rnd_valid_d;
      busy_q        <= busy_d;
      grant_count_q <= grant_count_d;
    end
  end

  assign gnt         = gnt_q;
  assign rnd_data    = rnd_data_q;
  assign rnd_valid   = rnd_valid_q;
  assign busy        = busy_q;
  assign grant_count = grant_count_q;

endmodule

// File: tb/tb_lfsr_rr_arbiter.sv
// Bench for lfsr_rr_arbiter (default build): models lfsr10 (XNOR taps 9/6, seed 10'h001) as
// stimulus and predicts grants, data values, latency and counts from the arbitration rules.
module tb_lfsr_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 10;
  localparam int ST = 4;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req   = '0;
  logic [W-1:0] lfsr_q = 10'h001;
  logic         lfsr_en;
  logic [N-1:0] gnt;
  logic [W-1:0] rnd_data;
  logic         rnd_valid;
  logic         busy;
  logic [15:0]  grant_count;

  int n_cmp  = 0;
  int n_err  = 0;
  int en_cnt = 0;

  // Reference model state.
  int           rr_m   = N - 1;
  int           cnt_m  = 0;
  int           exp_en = 0;
  logic [W-1:0] lfsr_m = 10'h001;

  lfsr_rr_arbiter #(
    .N_REQ(N),
    .WIDTH(W),
    .STEPS(ST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .lfsr_q     (lfsr_q),
    .lfsr_en    (lfsr_en),
    .gnt        (gnt),
    .rnd_data   (rnd_data),
    .rnd_valid  (rnd_valid),
    .busy       (busy),
    .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] lfsr_next(input logic [9:0] v);
    return {v[8:0], ~(v[9] ^ v[6])};
  endfunction

  function automatic logic [W-1:0] lfsr_adv(input logic [W-1:0] v, input int steps);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < steps; i++) r = lfsr_next(r);
    return r;
  endfunction

  // First set bit after ptr, wrapping modulo N.
  function automatic int rr_pick(input logic [N-1:0] m, input int ptr);
    for (int k = 1; k <= N; k++) begin
      if (m[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // External lfsr10 plus an enable-cycle counter.
  always @(posedge clk) begin
    if (lfsr_en) begin
      lfsr_q <= lfsr_next(lfsr_q);
      en_cnt <= en_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt === '0 && n < 40);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req   = '0;
    repeat (3) tick();
    n_cmp++;
    if ({gnt, rnd_valid, busy, lfsr_en} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b, required 0", {gnt, rnd_valid, busy, lfsr_en});
    end
    n_cmp++;
    if (rnd_data !== 10'h000) begin
      n_err++;
      $display("FAIL reset_data: got %h, required 000", rnd_data);
    end
    n_cmp++;
    if (grant_count !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_count: got %h, required 0000", grant_count);
    end
    reset = 1'b1;
    tick();
    rr_m  = N - 1;
    cnt_m = 0;
  endtask

  task automatic test_single_draw();
    int n;
    int e0;
    e0  = en_cnt;
    req = 4'b0001;
    lfsr_m = lfsr_adv(lfsr_m, ST);
    exp_en += ST;
    wait_grant(n);
    n_cmp++;
    if (n - 1 != ST + 2) begin
      n_err++;
      $display("FAIL first_latency: got %0d edges, required %0d", n - 1, ST + 2);
    end
    n_cmp++;
    if (en_cnt - e0 != ST) begin
      n_err++;
      $display("FAIL first_enables: got %0d, required %0d", en_cnt - e0, ST);
    end
    n_cmp++;
    if (gnt !== 4'b0001 || rnd_valid !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL first_grant: got gnt=%b valid=%b busy=%b, required 0001 1 1",
               gnt, rnd_valid, busy);
    end
    n_cmp++;
    if (rnd_data !== 10'h01F) begin
      n_err++;
      $display("FAIL first_data: got %h, required 01f", rnd_data);
    end
    req = 4'b0000;
    tick();
    cnt_m++;
    rr_m = 0;
    n_cmp++;
    if (gnt !== 4'b0000 || rnd_valid !== 1'b0 || grant_count !== 16'd1) begin
      n_err++;
      $display("FAIL first_release: got gnt=%b valid=%b count=%0d, required 0000 0 1",
               gnt, rnd_valid, grant_count);
    end
    e0 = en_cnt;
    repeat (2) tick();
    n_cmp++;
    if (en_cnt != e0 || rnd_data !== 10'h01F) begin
      n_err++;
      $display("FAIL idle_hold: got enables=%0d data=%h, required 0 01f", en_cnt - e0, rnd_data);
    end
    req = 4'b0001;
    lfsr_m = lfsr_adv(lfsr_m, ST);
    exp_en += ST;
    wait_grant(n);
    n_cmp++;
    if (gnt !== 4'b0001 || rnd_data !== 10'h1FC) begin
      n_err++;
      $display("FAIL second_draw: got gnt=%b data=%h, required 0001 1fc", gnt, rnd_data);
    end
    req = 4'b0000;
    tick();
    cnt_m++;
    n_cmp++;
    if (grant_count !== 16'(cnt_m)) begin
      n_err++;
      $display("FAIL second_count: got %0d, required %0d", grant_count, cnt_m);
    end
  endtask

  task automatic test_round_robin();
    int n;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] exp_g;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    rr_m  = N - 1;
    cnt_m = 0;
    req   = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      lfsr_m = lfsr_adv(lfsr_m, ST);
      exp_en += ST;
      wait_grant(n);
      exp_g = '0;
      exp_g[order[i]] = 1'b1;
      n_cmp++;
      if (gnt !== exp_g || n - 1 != ST + 2 || rnd_data !== lfsr_m) begin
        n_err++;
        $display("FAIL rr_grant%0d: got gnt=%b edges=%0d data=%h, required %b %0d %h",
                 i, gnt, n - 1, rnd_data, exp_g, ST + 2, lfsr_m);
      end
      req = 4'b1111 & ~exp_g;
      tick();
      cnt_m++;
      rr_m = order[i];
      n_cmp++;
      if (gnt !== 4'b0000 || grant_count !== 16'(cnt_m)) begin
        n_err++;
        $display("FAIL rr_release%0d: got gnt=%b count=%0d, required 0000 %0d",
                 i, gnt, grant_count, cnt_m);
      end
      req = (i == 4) ? 4'b0000 : 4'b1111;
    end
  endtask

  task automatic test_abandon();
    int n;
    int e0;
    int saw;
    logic [15:0] c0;
    e0  = en_cnt;
    c0  = grant_count;
    saw = 0;
    req = 4'b0100;
    tick();
    tick();
    req = 4'b0000;
    n = 0;
    do begin
      tick();
      n++;
      if (gnt !== '0) saw = 1;
    end while (busy === 1'b1 && n < 40);
    lfsr_m = lfsr_adv(lfsr_m, ST);
    exp_en += ST;
    rr_m = 2;
    n_cmp++;
    if (saw != 0 || busy !== 1'b0 || en_cnt - e0 != ST || grant_count !== c0) begin
      n_err++;
      $display("FAIL abandon: got gnt_seen=%0d busy=%b enables=%0d count=%0d, required 0 0 %0d %0d",
               saw, busy, en_cnt - e0, grant_count, ST, c0);
    end
    req = 4'b1111;
    lfsr_m = lfsr_adv(lfsr_m, ST);
    exp_en += ST;
    wait_grant(n);
    n_cmp++;
    if (gnt !== 4'b1000 || rnd_data !== lfsr_m) begin
      n_err++;
      $display("FAIL after_abandon: got gnt=%b data=%h, required 1000 %h", gnt, rnd_data, lfsr_m);
    end
    req = 4'b0000;
    tick();
    cnt_m++;
    rr_m = 3;
  endtask

  task automatic test_reset_in_grant();
    int n;
    req = 4'b0010;
    lfsr_m = lfsr_adv(lfsr_m, ST);
    exp_en += ST;
    wait_grant(n);
    n_cmp++;
    if (gnt !== 4'b0010) begin
      n_err++;
      $display("FAIL pre_reset_grant: got %b, required 0010", gnt);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (gnt !== '0 || rnd_valid !== 1'b0 || busy !== 1'b0 || grant_count !== 16'd0 ||
        rnd_data !== '0 || lfsr_en !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got gnt=%b valid=%b busy=%b count=%0d data=%h en=%b, required all 0",
               gnt, rnd_valid, busy, grant_count, rnd_data, lfsr_en);
    end
    req = 4'b0000;
    tick();
    reset = 1'b1;
    tick();
    rr_m  = N - 1;
    cnt_m = 0;
  endtask

  task automatic test_saturation();
    int n;
    force dut.grant_count_q = 16'hFFFF;
    tick();
    release dut.grant_count_q;
    tick();
    n_cmp++;
    if (grant_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat_preload: got %h, required ffff", grant_count);
    end
    req = 4'b0001;
    lfsr_m = lfsr_adv(lfsr_m, ST);
    exp_en += ST;
    wait_grant(n);
    req = 4'b0000;
    tick();
    rr_m = 0;
    n_cmp++;
    if (grant_count !== 16'hFFFF || gnt !== '0) begin
      n_err++;
      $display("FAIL saturate: got count=%h gnt=%b, required ffff 0000", grant_count, gnt);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    rr_m  = N - 1;
    cnt_m = 0;
  endtask

  task automatic test_random();
    int n;
    int gap;
    int hold;
    int exp_idx;
    int e0;
    logic [N-1:0] mask;
    logic [N-1:0] exp_g;
    for (int it = 0; it < 30; it++) begin
      mask = 4'($urandom_range(1, 15));
      gap  = int'($urandom_range(0, 2));
      if (gap > 0) begin
        req = '0;
        e0  = en_cnt;
        repeat (gap) tick();
        n_cmp++;
        if (en_cnt != e0 || busy !== 1'b0) begin
          n_err++;
          $display("FAIL rnd_idle%0d: got enables=%0d busy=%b, required 0 0", it, en_cnt - e0, busy);
        end
      end
      req     = mask;
      exp_idx = rr_pick(mask, rr_m);
      exp_g   = '0;
      exp_g[exp_idx] = 1'b1;
      lfsr_m  = lfsr_adv(lfsr_m, ST);
      exp_en += ST;
      wait_grant(n);
      n_cmp++;
      if (n - 1 != ST + 2) begin
        n_err++;
        $display("FAIL rnd_latency%0d: got %0d edges, required %0d", it, n - 1, ST + 2);
      end
      n_cmp++;
      if (gnt !== exp_g || rnd_valid !== 1'b1) begin
        n_err++;
        $display("FAIL rnd_grant%0d: got gnt=%b valid=%b, required %b 1 (mask %b)",
                 it, gnt, rnd_valid, exp_g, mask);
      end
      n_cmp++;
      if (rnd_data !== lfsr_m || en_cnt != exp_en) begin
        n_err++;
        $display("FAIL rnd_data%0d: got data=%h enables=%0d, required %h %0d",
                 it, rnd_data, en_cnt, lfsr_m, exp_en);
      end
      hold = int'($urandom_range(0, 3));
      for (int h = 0; h < hold; h++) begin
        req = 4'($urandom_range(0, 15)) | exp_g;
        tick();
        n_cmp++;
        if (gnt !== exp_g || rnd_data !== lfsr_m) begin
          n_err++;
          $display("FAIL rnd_hold%0d: got gnt=%b data=%h, required %b %h",
                   it, gnt, rnd_data, exp_g, lfsr_m);
        end
      end
      req = 4'($urandom_range(0, 15)) & ~exp_g;
      tick();
      cnt_m++;
      rr_m = exp_idx;
      n_cmp++;
      if (gnt !== '0 || rnd_valid !== 1'b0 || busy !== 1'b0 || grant_count !== 16'(cnt_m) ||
          rnd_data !== lfsr_m) begin
        n_err++;
        $display("FAIL rnd_release%0d: got gnt=%b valid=%b busy=%b count=%0d data=%h, required 0 0 0 %0d %h",
                 it, gnt, rnd_valid, busy, grant_count, rnd_data, cnt_m, lfsr_m);
      end
    end
    req = '0;
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_draw();
    test_round_robin();
    test_abandon();
    test_reset_in_grant();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
